// File: rtl/lockin_pkg.sv
// Shared definitions for the lock-in averaging path: sequencer state encoding
// and the averager result width derivation.
package lockin_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // Averager output carries the full accumulation: sample width plus factor width.
  function automatic int unsigned out_bits_f(input int unsigned input_data_bits,
                                             input int unsigned averaging_points_bits);
    return input_data_bits + averaging_points_bits;
  endfunction

endpackage

// File: rtl/averager_sequencer_if.sv
// Result pair handshake between the averager sequencer and the packetiser.
interface averager_sequencer_if
  import lockin_pkg::*;
#(
  parameter int unsigned OUT_BITS = out_bits_f(16, 16)
) ();

  logic [OUT_BITS-1:0] out_data_1;
  logic [OUT_BITS-1:0] out_data_2;
  logic                out_valid;
  logic                out_ready;

  modport master (output out_data_1, output out_data_2, output out_valid, input out_ready);
  modport slave  (input out_data_1, input out_data_2, input out_valid, output out_ready);

endinterface

// File: rtl/result_skid_reg.sv
// Single-entry valid/ready buffer; a load while full and not draining is dropped.
module result_skid_reg #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              drop_c
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_c  = 1'b0;
    if (in_valid) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else begin
        drop_c  = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/averager_sequencer.sv
// Sequencer for the dual averager: latches config, clears/gates the averagers,
// counts result frames and buffers each (I,Q) pair toward the packetiser.
module averager_sequencer
  import lockin_pkg::*;
#(
  parameter int unsigned AVERAGING_POINTS_BITS = 16,
  parameter int unsigned INPUT_DATA_BITS       = 16,
  parameter int unsigned FRAME_BITS            = 16
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [AVERAGING_POINTS_BITS-1:0]             cfg_averaging_points,
  input  logic [FRAME_BITS-1:0]                        cfg_num_frames,
  input  logic                                         start,
  input  logic                                         stop,
  input  logic                                         sample_valid,
  output logic [AVERAGING_POINTS_BITS-1:0]             avg_points,
  output logic                                         avg_shift,
  output logic                                         avg_clear,
  output logic                                         run_averaging,
  input  logic [INPUT_DATA_BITS+AVERAGING_POINTS_BITS-1:0] avg_data_1,
  input  logic [INPUT_DATA_BITS+AVERAGING_POINTS_BITS-1:0] avg_data_2,
  input  logic                                         avg_data_valid,
  output logic                                         busy,
  output logic [FRAME_BITS-1:0]                        frames_done,
  output logic                                         overflow,
  output logic                                         cfg_error,
  averager_sequencer_if.master                         res
);

  localparam int unsigned OUT_BITS = out_bits_f(INPUT_DATA_BITS, AVERAGING_POINTS_BITS);

  logic [1:0]                       state_q, state_d;
  logic [AVERAGING_POINTS_BITS-1:0] avg_points_q, avg_points_d;
  logic                             avg_shift_q, avg_shift_d;
  logic [FRAME_BITS-1:0]            num_frames_q, num_frames_d;
  logic [FRAME_BITS-1:0]            frames_done_q, frames_done_d;
  logic                             overflow_q, overflow_d;
  logic                             cfg_error_q, cfg_error_d;
  logic                             busy_q, busy_d;

  logic                             accept_c;
  logic                             pow2_c;
  logic [FRAME_BITS-1:0]            frames_inc_c;
  logic                             buf_valid;
  logic                             drop_c;
  logic [2*OUT_BITS-1:0]            buf_data;

  assign accept_c     = avg_data_valid && (state_q == ST_RUN || state_q == ST_DRAIN);
  assign pow2_c       = (cfg_averaging_points &
                         (cfg_averaging_points - AVERAGING_POINTS_BITS'(1))) == '0;
  assign frames_inc_c = (frames_done_q == '1) ? frames_done_q
                                              : frames_done_q + FRAME_BITS'(1);

  // Next-state, config latch, frame counter and sticky flags.
  always_comb begin
    state_d       = state_q;
    avg_points_d  = avg_points_q;
    avg_shift_d   = avg_shift_q;
    num_frames_d  = num_frames_q;
    frames_done_d = frames_done_q;
    overflow_d    = overflow_q;
    cfg_error_d   = cfg_error_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_averaging_points != '0) begin
            state_d       = ST_CLEAR;
            avg_points_d  = cfg_averaging_points;
            avg_shift_d   = pow2_c;
            num_frames_d  = cfg_num_frames;
            frames_done_d = '0;
            overflow_d    = 1'b0;
            cfg_error_d   = 1'b0;
          end else begin
            cfg_error_d   = 1'b1;
          end
        end
      end
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (accept_c && num_frames_q != '0 && frames_inc_c == num_frames_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!buf_valid && !accept_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_c) frames_done_d = frames_inc_c;
    if (drop_c)   overflow_d    = 1'b1;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      avg_points_q  <= '0;
      avg_shift_q   <= 1'b0;
      num_frames_q  <= '0;
      frames_done_q <= '0;
      overflow_q    <= 1'b0;
      cfg_error_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      avg_points_q  <= avg_points_d;
      avg_shift_q   <= avg_shift_d;
      num_frames_q  <= num_frames_d;
      frames_done_q <= frames_done_d;
      overflow_q    <= overflow_d;
      cfg_error_q   <= cfg_error_d;
      busy_q        <= busy_d;
    end
  end

  // Stop discards the partial average in the same cycle it is seen.
  assign avg_clear     = (state_q == ST_CLEAR) || (state_q == ST_RUN && stop);
  assign run_averaging = (state_q == ST_RUN) && sample_valid;

  result_skid_reg #(.DATA_W(2*OUT_BITS)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (accept_c),
    .in_data   ({avg_data_2, avg_data_1}),
    .out_ready (res.out_ready),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .drop_c    (drop_c)
  );

  assign res.out_valid  = buf_valid;
  assign res.out_data_1 = buf_data[OUT_BITS-1:0];
  assign res.out_data_2 = buf_data[2*OUT_BITS-1:OUT_BITS];

  assign avg_points  = avg_points_q;
  assign avg_shift   = avg_shift_q;
  assign frames_done = frames_done_q;
  assign overflow    = overflow_q;
  assign cfg_error   = cfg_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_averager_sequencer.sv
// Directed bench for averager_sequencer with a simple summing averager model.
module tb_averager_sequencer;

  logic        clock;
  logic        reset;
  logic [15:0] cfg_averaging_points;
  logic [15:0] cfg_num_frames;
  logic        start, stop, sample_valid;
  logic [15:0] avg_points;
  logic        avg_shift, avg_clear, run_averaging;
  logic [31:0] avg_data_1, avg_data_2;
  logic        avg_data_valid;
  logic        busy;
  logic [15:0] frames_done;
  logic        overflow, cfg_error;

  averager_sequencer_if #(.OUT_BITS(32)) res_if ();

  averager_sequencer dut (
    .clock                (clock),
    .reset                (reset),
    .cfg_averaging_points (cfg_averaging_points),
    .cfg_num_frames       (cfg_num_frames),
    .start                (start),
    .stop                 (stop),
    .sample_valid         (sample_valid),
    .avg_points           (avg_points),
    .avg_shift            (avg_shift),
    .avg_clear            (avg_clear),
    .run_averaging        (run_averaging),
    .avg_data_1           (avg_data_1),
    .avg_data_2           (avg_data_2),
    .avg_data_valid       (avg_data_valid),
    .busy                 (busy),
    .frames_done          (frames_done),
    .overflow             (overflow),
    .cfg_error            (cfg_error),
    .res                  (res_if.master)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Averager model: samples valued 1,2,3,... after each clear; result = sum, sum+100.
  logic        model_en, m_valid, man_valid;
  logic [31:0] m_d1, m_d2, man_d1, man_d2;
  logic        clr_s, run_s;
  int          acc, cnt, n;

  assign avg_data_valid = model_en ? m_valid : man_valid;
  assign avg_data_1     = model_en ? m_d1 : man_d1;
  assign avg_data_2     = model_en ? m_d2 : man_d2;

  initial begin
    m_valid = 1'b0; m_d1 = '0; m_d2 = '0; acc = 0; cnt = 0; n = 0;
    clr_s = 1'b0; run_s = 1'b0;
  end

  always @(negedge clock) begin
    clr_s = avg_clear;
    run_s = run_averaging;
  end

  always @(posedge clock) begin
    #1;
    m_valid = 1'b0;
    if (clr_s) begin
      acc = 0; cnt = 0; n = 0;
    end else if (run_s) begin
      n++;
      acc += n;
      cnt++;
      if (cnt == int'(avg_points)) begin
        m_d1 = 32'(acc);
        m_d2 = 32'(acc + 100);
        m_valid = 1'b1;
        acc = 0; cnt = 0;
      end
    end
  end

  // Transfer log of accepted pairs.
  int          xfer_n;
  logic [31:0] xfer_d1 [64];
  logic [31:0] xfer_d2 [64];

  initial xfer_n = 0;

  always @(negedge clock) begin
    if (res_if.out_valid && res_if.out_ready && xfer_n < 64) begin
      xfer_d1[xfer_n] = res_if.out_data_1;
      xfer_d2[xfer_n] = res_if.out_data_2;
      xfer_n++;
    end
  end

  int n_cmp, n_bad;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    expect_eq(tag, 64'(busy), 64'd0);
  endtask

  task automatic do_start(input logic [15:0] pts, input logic [15:0] frames);
    @(posedge clock);
    #1;
    cfg_averaging_points = pts;
    cfg_num_frames       = frames;
    start                = 1'b1;
    tick();
    start                = 1'b0;
  endtask

  int base;

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    cfg_averaging_points = '0; cfg_num_frames = '0;
    model_en = 1'b0; man_valid = 1'b0; man_d1 = '0; man_d2 = '0;
    res_if.out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Reset state
    @(negedge clock);
    expect_eq("rst_busy",      64'(busy),            64'd0);
    expect_eq("rst_out_valid", 64'(res_if.out_valid), 64'd0);
    expect_eq("rst_points",    64'(avg_points),      64'd0);
    expect_eq("rst_frames",    64'(frames_done),     64'd0);
    expect_eq("rst_clear",     64'(avg_clear),       64'd0);

    // points=4, frames=3, continuous samples, always ready
    model_en = 1'b1; sample_valid = 1'b1; res_if.out_ready = 1'b1;
    base = xfer_n;
    do_start(16'd4, 16'd3);
    @(negedge clock);
    expect_eq("t1_clear",  64'(avg_clear),     64'd1);
    expect_eq("t1_shift",  64'(avg_shift),     64'd1);
    expect_eq("t1_points", 64'(avg_points),    64'd4);
    expect_eq("t1_busy",   64'(busy),          64'd1);
    expect_eq("t1_run0",   64'(run_averaging), 64'd0);
    wait_idle("t1_idle", 200);
    expect_eq("t1_nxfer",  64'(xfer_n - base), 64'd3);
    expect_eq("t1_d1_0",   64'(xfer_d1[base]),   64'd10);
    expect_eq("t1_d1_1",   64'(xfer_d1[base+1]), 64'd26);
    expect_eq("t1_d1_2",   64'(xfer_d1[base+2]), 64'd42);
    expect_eq("t1_d2_2",   64'(xfer_d2[base+2]), 64'd142);
    expect_eq("t1_frames", 64'(frames_done),     64'd3);
    expect_eq("t1_ovf",    64'(overflow),        64'd0);

    // points=5 -> no shift; then points=0 rejected
    do_start(16'd5, 16'd0);
    @(negedge clock);
    expect_eq("t2_shift",  64'(avg_shift),  64'd0);
    expect_eq("t2_points", 64'(avg_points), 64'd5);
    @(posedge clock);
    #1 stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle("t2_idle", 50);
    do_start(16'd0, 16'd0);
    @(negedge clock);
    expect_eq("t2_cfgerr", 64'(cfg_error),  64'd1);
    expect_eq("t2_busy",   64'(busy),       64'd0);
    expect_eq("t2_noclr",  64'(avg_clear),  64'd0);
    expect_eq("t2_keep",   64'(avg_points), 64'd5);

    // Back-pressure: second result dropped, first held
    model_en = 1'b0; sample_valid = 1'b0; res_if.out_ready = 1'b0;
    do_start(16'd1, 16'd0);
    @(negedge clock);
    expect_eq("t3_cfgclr", 64'(cfg_error), 64'd0);
    expect_eq("t3_shift1", 64'(avg_shift), 64'd1);
    @(posedge clock);
    #1 man_valid = 1'b1; man_d1 = 32'h11; man_d2 = 32'h22;
    tick();
    man_d1 = 32'h33; man_d2 = 32'h44;
    tick();
    man_valid = 1'b0;
    @(negedge clock);
    expect_eq("t3_valid",  64'(res_if.out_valid),  64'd1);
    expect_eq("t3_d1",     64'(res_if.out_data_1), 64'h11);
    expect_eq("t3_d2",     64'(res_if.out_data_2), 64'h22);
    expect_eq("t3_ovf",    64'(overflow),          64'd1);
    expect_eq("t3_frames", 64'(frames_done),       64'd2);
    @(posedge clock);
    #1 stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clock);
    expect_eq("t3_drain_busy", 64'(busy),             64'd1);
    expect_eq("t3_held",       64'(res_if.out_valid), 64'd1);
    base = xfer_n;
    @(posedge clock);
    #1 res_if.out_ready = 1'b1;
    wait_idle("t3_idle", 20);
    expect_eq("t3_nxfer", 64'(xfer_n - base),  64'd1);
    expect_eq("t3_xd1",   64'(xfer_d1[base]),  64'h11);
    expect_eq("t3_empty", 64'(res_if.out_valid), 64'd0);

    // Continuous mode, stop with a partial accumulation
    model_en = 1'b1; sample_valid = 1'b1;
    base = xfer_n;
    do_start(16'd4, 16'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (frames_done == 16'd2) break;
    end
    expect_eq("t4_two", 64'(frames_done), 64'd2);
    @(posedge clock);
    #1 stop = 1'b1;
    @(negedge clock);
    expect_eq("t4_clear", 64'(avg_clear), 64'd1);
    @(posedge clock);
    #1 stop = 1'b0;
    @(negedge clock);
    expect_eq("t4_run0",   64'(run_averaging), 64'd0);
    wait_idle("t4_idle", 20);
    expect_eq("t4_frames", 64'(frames_done),    64'd2);
    expect_eq("t4_nxfer",  64'(xfer_n - base),  64'd2);
    expect_eq("t4_d1_0",   64'(xfer_d1[base]),   64'd10);
    expect_eq("t4_d1_1",   64'(xfer_d1[base+1]), 64'd26);

    // stop + start + result in one RUN cycle
    model_en = 1'b0; sample_valid = 1'b0;
    base = xfer_n;
    do_start(16'd2, 16'd0);
    @(posedge clock);
    #1;
    man_valid = 1'b1; man_d1 = 32'h55; man_d2 = 32'h66;
    stop = 1'b1; start = 1'b1; cfg_averaging_points = 16'd7;
    tick();
    man_valid = 1'b0; stop = 1'b0; start = 1'b0;
    @(negedge clock);
    expect_eq("t5_busy",   64'(busy),               64'd1);
    expect_eq("t5_noclr",  64'(avg_clear),          64'd0);
    expect_eq("t5_valid",  64'(res_if.out_valid),   64'd1);
    expect_eq("t5_d1",     64'(res_if.out_data_1),  64'h55);
    expect_eq("t5_frames", 64'(frames_done),        64'd1);
    expect_eq("t5_points", 64'(avg_points),         64'd2);
    wait_idle("t5_idle", 20);
    expect_eq("t5_nxfer",  64'(xfer_n - base), 64'd1);
    expect_eq("t5_fkeep",  64'(frames_done),   64'd1);

    // Reset during RUN with a buffered pair, then a fresh run
    res_if.out_ready = 1'b0; sample_valid = 1'b1;
    do_start(16'd4, 16'd0);
    @(posedge clock);
    #1 man_valid = 1'b1; man_d1 = 32'h77; man_d2 = 32'h88;
    tick();
    man_valid = 1'b0;
    @(negedge clock);
    expect_eq("t6_pre_valid", 64'(res_if.out_valid), 64'd1);
    reset = 1'b0;
    #1;
    expect_eq("t6_valid",  64'(res_if.out_valid),  64'd0);
    expect_eq("t6_d1",     64'(res_if.out_data_1), 64'd0);
    expect_eq("t6_busy",   64'(busy),              64'd0);
    expect_eq("t6_frames", 64'(frames_done),       64'd0);
    expect_eq("t6_points", 64'(avg_points),        64'd0);
    expect_eq("t6_run",    64'(run_averaging),     64'd0);
    expect_eq("t6_ovf",    64'(overflow),          64'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    model_en = 1'b1; res_if.out_ready = 1'b1;
    base = xfer_n;
    do_start(16'd8, 16'd1);
    wait_idle("t6_idle", 100);
    expect_eq("t6_nxfer",  64'(xfer_n - base),  64'd1);
    expect_eq("t6_xd1",    64'(xfer_d1[base]),  64'd36);
    expect_eq("t6_xd2",    64'(xfer_d2[base]),  64'd136);
    expect_eq("t6_fdone",  64'(frames_done),    64'd1);
    expect_eq("t6_shift",  64'(avg_shift),      64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/averager_sequencer.md
Name: averager_sequencer

Overview:
Control block for the lock-in dual averaging stage. Latches averaging configuration, clears and gates the paired averagers, counts completed averaging frames and buffers each (I,Q) result pair behind a valid/ready handshake toward the packetiser. Sits between the demodulator sample strobe and the dual averager instance in the fast ADC lock-in path.

Parameters:
AVERAGING_POINTS_BITS, 16, width of the averaging factor; max factor (2^AVERAGING_POINTS_BITS)-1
INPUT_DATA_BITS, 16, width of each averager input sample
FRAME_BITS, 16, width of the frame counter and frame request
- Derived, not a parameter: OUT_BITS = INPUT_DATA_BITS + AVERAGING_POINTS_BITS.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
cfg_averaging_points  in  AVERAGING_POINTS_BITS  requested averaging factor, sampled on accepted start
cfg_num_frames  in  FRAME_BITS  frames to acquire; 0 = continuous until stop
start  in  1  single-cycle start request
stop  in  1  single-cycle stop request
sample_valid  in  1  demodulator output strobe
avg_points  out  AVERAGING_POINTS_BITS  latched factor to averagers
avg_shift  out  1  to averager shift input
avg_clear  out  1  one-cycle active-high clear to averagers
run_averaging  out  1  averager sample enable
avg_data_1  in  OUT_BITS  averager channel 1 result
avg_data_2  in  OUT_BITS  averager channel 2 result
avg_data_valid  in  1  combined averager result strobe, one-cycle pulse
out_data_1  out  OUT_BITS  buffered channel 1 result
out_data_2  out  OUT_BITS  buffered channel 2 result
out_valid  out  1  buffered pair available
out_ready  in  1  downstream accepts pair
busy  out  1  state != IDLE
frames_done  out  FRAME_BITS  results received since last start
overflow  out  1  sticky: result dropped, cleared on accepted start
cfg_error  out  1  sticky: start rejected for cfg_averaging_points == 0, cleared on next accepted start

Behaviour:
- Reset: every output 0. State IDLE. Output buffer empty.
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE: start with cfg_averaging_points != 0 -> latch avg_points, avg_shift and num_frames; clear frames_done, overflow and cfg_error; go to CLEAR. start with points == 0 -> set cfg_error and remain in IDLE. stop in IDLE is ignored.
- avg_shift = 1 iff the latched points value is a power of two (points & (points-1) == 0). This includes 1, which is a shift by 0.
- CLEAR: avg_clear = 1 for exactly one cycle; run_averaging = 0; go to RUN next cycle. The first sample can be enabled 2 cycles after start.
- RUN: run_averaging = sample_valid (combinational AND with the registered state).
- Every avg_data_valid in RUN or DRAIN increments frames_done. frames_done saturates at all-ones.
- Buffer: one pair register. On avg_data_valid:
  - If the buffer is empty, or out_ready = 1 in the same cycle, load avg_data_1/2 and set out_valid next cycle.
  - Otherwise keep the old pair, drop the new one and set overflow.
- out_valid && out_ready with no load empties the buffer next cycle. Data is stable while out_valid = 1 and out_ready = 0.
- RUN exit: when num_frames != 0 and the increment makes frames_done == num_frames, go to DRAIN.
- stop in RUN -> DRAIN, and pulse avg_clear in the transition cycle so the partial average is discarded.
- stop in the same cycle as avg_data_valid: the result is still captured and counted.
- start + stop together in RUN: stop wins. start outside IDLE is ignored.
- DRAIN: run_averaging = 0; go to IDLE in the cycle after the buffer becomes empty. A late avg_data_valid in DRAIN is buffered and counted under the same rules.
- Mid-operation reset (reset low): asynchronous return to reset values. Any buffered pair is lost.
- Config inputs are not observed outside the start cycle.

Decomposition:
- Shared lockin_pkg holds the state encoding localparams (IDLE=0, CLEAR=1, RUN=2, DRAIN=3) and the OUT_BITS derivation.
- One sub-module: result_skid_reg, the single-entry valid/ready pair buffer with a drop/overflow output.
- The FSM, counter and power-of-two detect stay in the top level.

Test Plan:
- points=4, frames=3, sample_valid every cycle, out_ready=1; model averager -> avg_clear pulse at cycle 1, avg_shift=1, exactly 3 out_valid pulses with model averages, frames_done=3, then busy=0.
- points=5 -> avg_shift=0; points=0 start -> cfg_error=1, busy stays 0, no avg_clear.
- out_ready=0, two avg_data_valid pulses -> first pair held on out_data, overflow=1, frames_done=2; then raise out_ready -> single transfer, return to IDLE after the buffer empties.
- frames=0 continuous, stop after 2 results with a partial accumulation -> avg_clear pulse on stop, run_averaging=0 the next cycle, frames_done=2.
- stop coincident with avg_data_valid, plus start+stop in RUN -> result captured and counted; state goes to DRAIN, not restart.
- reset low during RUN with out_valid=1 -> all outputs 0 immediately; a new start works normally afterwards.
